// File: rtl/gl_prim_assembly.sv
// gl_prim_assembly
//   Primitive assembly after the viewport transform. Groups incoming
//   window-space vertices (with colours) into triangles according to the
//   glBegin mode latched at begin_en, and hands one triangle at a time to the
//   rasterizer over a valid/ready handshake. Data words pass bit-exact.
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   begin_en, end_en      : glBegin / glEnd pulses (begin_en wins if both)
//   prim_mode             : 0 list, 1 strip, 2 fan, 3 treated as list
//   vert_valid/vert_ready : vertex input handshake, vertex_in + color_in
//   tri_valid/tri_ready   : triangle output handshake, tri_v0..2 + tri_c0..2
//   active                : high between begin_en and end_en
module gl_prim_assembly #(
    parameter int unsigned VERT_W  = 96,
    parameter int unsigned COLOR_W = 96
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               begin_en,
    input  logic               end_en,
    input  logic [1:0]         prim_mode,
    input  logic               vert_valid,
    output logic               vert_ready,
    input  logic [VERT_W-1:0]  vertex_in,
    input  logic [COLOR_W-1:0] color_in,
    output logic               tri_valid,
    input  logic               tri_ready,
    output logic [VERT_W-1:0]  tri_v0,
    output logic [VERT_W-1:0]  tri_v1,
    output logic [VERT_W-1:0]  tri_v2,
    output logic [COLOR_W-1:0] tri_c0,
    output logic [COLOR_W-1:0] tri_c1,
    output logic [COLOR_W-1:0] tri_c2,
    output logic               active
);

    localparam logic [1:0] ModeList  = 2'd0;
    localparam logic [1:0] ModeStrip = 2'd1;
    localparam logic [1:0] ModeFan   = 2'd2;

    logic               active_q, active_d;
    logic [1:0]         mode_q, mode_d;
    logic [1:0]         count_q, count_d;
    logic               parity_q, parity_d;
    logic [VERT_W-1:0]  a_v_q, a_v_d, b_v_q, b_v_d;
    logic [COLOR_W-1:0] a_c_q, a_c_d, b_c_q, b_c_d;
    logic               tri_valid_q, tri_valid_d;
    logic [VERT_W-1:0]  v0_q, v0_d, v1_q, v1_d, v2_q, v2_d;
    logic [COLOR_W-1:0] c0_q, c0_d, c1_q, c1_d, c2_q, c2_d;
    logic               accept;
    logic               swap;

    // A new vertex may only enter when the output register is free or is
    // being drained this same cycle, so an emit never overwrites a triangle.
    assign vert_ready = active_q & ~begin_en & ~end_en & (~tri_valid_q | tri_ready);
    assign accept     = vert_valid & vert_ready;
    // Odd strip triangles swap the first two vertices to keep winding consistent.
    assign swap       = (mode_q == ModeStrip) & parity_q;

    always_comb begin
        active_d    = active_q;
        mode_d      = mode_q;
        count_d     = count_q;
        parity_d    = parity_q;
        a_v_d       = a_v_q;
        a_c_d       = a_c_q;
        b_v_d       = b_v_q;
        b_c_d       = b_c_q;
        tri_valid_d = tri_valid_q & ~tri_ready;
        v0_d        = v0_q;
        v1_d        = v1_q;
        v2_d        = v2_q;
        c0_d        = c0_q;
        c1_d        = c1_q;
        c2_d        = c2_q;

        if (accept) begin
            case (count_q)
                2'd0: begin
                    a_v_d   = vertex_in;
                    a_c_d   = color_in;
                    count_d = 2'd1;
                end
                2'd1: begin
                    b_v_d   = vertex_in;
                    b_c_d   = color_in;
                    count_d = 2'd2;
                end
                default: begin
                    tri_valid_d = 1'b1;
                    v0_d        = swap ? b_v_q : a_v_q;
                    c0_d        = swap ? b_c_q : a_c_q;
                    v1_d        = swap ? a_v_q : b_v_q;
                    c1_d        = swap ? a_c_q : b_c_q;
                    v2_d        = vertex_in;
                    c2_d        = color_in;
                    case (mode_q)
                        ModeStrip: begin
                            a_v_d    = b_v_q;
                            a_c_d    = b_c_q;
                            b_v_d    = vertex_in;
                            b_c_d    = color_in;
                            parity_d = ~parity_q;
                        end
                        ModeFan: begin
                            b_v_d = vertex_in;
                            b_c_d = color_in;
                        end
                        default: count_d = 2'd0;
                    endcase
                end
            endcase
        end

        // Mode changes never touch a pending triangle; it still transfers.
        if (begin_en) begin
            active_d = 1'b1;
            mode_d   = (prim_mode == 2'd3) ? ModeList : prim_mode;
            count_d  = 2'd0;
            parity_d = 1'b0;
        end else if (end_en) begin
            active_d = 1'b0;
            count_d  = 2'd0;
            parity_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q    <= 1'b0;
            mode_q      <= ModeList;
            count_q     <= 2'd0;
            parity_q    <= 1'b0;
            a_v_q       <= '0;
            a_c_q       <= '0;
            b_v_q       <= '0;
            b_c_q       <= '0;
            tri_valid_q <= 1'b0;
            v0_q        <= '0;
            v1_q        <= '0;
            v2_q        <= '0;
            c0_q        <= '0;
            c1_q        <= '0;
            c2_q        <= '0;
        end else begin
            active_q    <= active_d;
            mode_q      <= mode_d;
            count_q     <= count_d;
            parity_q    <= parity_d;
            a_v_q       <= a_v_d;
            a_c_q       <= a_c_d;
            b_v_q       <= b_v_d;
            b_c_q       <= b_c_d;
            tri_valid_q <= tri_valid_d;
            v0_q        <= v0_d;
            v1_q        <= v1_d;
            v2_q        <= v2_d;
            c0_q        <= c0_d;
            c1_q        <= c1_d;
            c2_q        <= c2_d;
        end
    end

    assign active    = active_q;
    assign tri_valid = tri_valid_q;
    assign tri_v0    = v0_q;
    assign tri_v1    = v1_q;
    assign tri_v2    = v2_q;
    assign tri_c0    = c0_q;
    assign tri_c1    = c1_q;
    assign tri_c2    = c2_q;

endmodule

// File: tb/tb_gl_prim_assembly.sv
module tb_gl_prim_assembly;

    logic        clk = 1'b0;
    logic        reset;
    logic        begin_en, end_en;
    logic [1:0]  prim_mode;
    logic        vert_valid, vert_ready;
    logic [95:0] vertex_in, color_in;
    logic        tri_valid, tri_ready;
    logic [95:0] tri_v0, tri_v1, tri_v2, tri_c0, tri_c1, tri_c2;
    logic        active;

    gl_prim_assembly #(.VERT_W(96), .COLOR_W(96)) dut (
        .clk        (clk),
        .reset      (reset),
        .begin_en   (begin_en),
        .end_en     (end_en),
        .prim_mode  (prim_mode),
        .vert_valid (vert_valid),
        .vert_ready (vert_ready),
        .vertex_in  (vertex_in),
        .color_in   (color_in),
        .tri_valid  (tri_valid),
        .tri_ready  (tri_ready),
        .tri_v0     (tri_v0),
        .tri_v1     (tri_v1),
        .tri_v2     (tri_v2),
        .tri_c0     (tri_c0),
        .tri_c1     (tri_c1),
        .tri_c2     (tri_c2),
        .active     (active)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: the list of vertices accepted since the last glBegin;
    // triangles are derived from vertex indices per primitive type.
    logic [95:0]  mv[$];
    logic [95:0]  mc[$];
    int           mmode;
    logic [575:0] exp_q[$];
    logic [575:0] obs_q[$];
    bit           rnd_ready = 0;

    function automatic logic [575:0] mk(int i, int j, int k);
        return {mv[i], mv[j], mv[k], mc[i], mc[j], mc[k]};
    endfunction

    task automatic model_accept(input logic [95:0] v, input logic [95:0] c);
        int n;
        mv.push_back(v);
        mc.push_back(c);
        n = mv.size() - 1;
        if (mmode == 0) begin
            if (n % 3 == 2) exp_q.push_back(mk(n - 2, n - 1, n));
        end else if (n >= 2) begin
            if (mmode == 2)                exp_q.push_back(mk(0, n - 1, n));
            else if ((n - 2) % 2 == 0)     exp_q.push_back(mk(n - 2, n - 1, n));
            else                           exp_q.push_back(mk(n - 1, n - 2, n));
        end
    endtask

    // Transfer monitor: records every handshake, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset && tri_valid && tri_ready)
            obs_q.push_back({tri_v0, tri_v1, tri_v2, tri_c0, tri_c1, tri_c2});
    end

    // Random back-pressure source for the randomized test.
    always @(posedge clk) begin
        if (rnd_ready) begin
            #1 tri_ready = ($urandom_range(0, 3) != 0);
        end
    end

    function automatic logic [95:0] rnd96();
        return {$urandom, $urandom, $urandom};
    endfunction

    task automatic do_begin(input int m);
        begin_en  = 1'b1;
        prim_mode = m[1:0];
        @(posedge clk); #1;
        begin_en = 1'b0;
        mv.delete();
        mc.delete();
        mmode = (m == 3) ? 0 : m;
    endtask

    task automatic do_end();
        end_en = 1'b1;
        @(posedge clk); #1;
        end_en = 1'b0;
        mv.delete();
        mc.delete();
    endtask

    task automatic drive_vert(input logic [95:0] v, input logic [95:0] c);
        int n = 0;
        vertex_in  = v;
        color_in   = c;
        vert_valid = 1'b1;
        while (n < 200) begin
            @(negedge clk);
            if (vert_ready) break;
            n++;
        end
        if (n == 200) begin
            errors++;
            checks++;
            $display("FAIL vert_ready_timeout: vert_ready=%b required=1", vert_ready);
        end
        @(posedge clk); #1;
        vert_valid = 1'b0;
        if (n < 200) model_accept(v, c);
    endtask

    task automatic drain();
        int n = 0;
        tri_ready = 1'b1;
        while (n < 200 && obs_q.size() < exp_q.size()) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; begin_en = 0; end_en = 0; prim_mode = 0;
        vert_valid = 0; vertex_in = 0; color_in = 0; tri_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({tri_valid, active, vert_ready} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 000", {tri_valid, active, vert_ready});
        end
        checks++;
        if ({tri_v0, tri_v1, tri_v2, tri_c0, tri_c1, tri_c2} !== 576'd0) begin
            errors++;
            $display("FAIL reset_data: tri outputs not zero");
        end
        reset = 1'b0;
        @(posedge clk); #1;
        vert_valid = 1'b1;
        #1;
        checks++;
        if (vert_ready !== 1'b0) begin
            errors++;
            $display("FAIL inactive_ready: got %b required 0", vert_ready);
        end
        vert_valid = 1'b0;
    endtask

    task automatic check_queues(input string name);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL %s_count: got %0d triangles required %0d", name, obs_q.size(),
                     exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s_tri%0d: got %h required %h", name, i, obs_q[i][575:288],
                         exp_q[i][575:288]);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic run_seq(input int m, input int nv, input string name);
        tri_ready = 1'b1;
        do_begin(m);
        for (int i = 0; i < nv; i++) begin
            drive_vert(rnd96(), rnd96());
            if (m == 0 && i % 3 == 2) begin
                checks++;
                if (tri_valid !== 1'b1 || tri_v2 !== mv[i]) begin
                    errors++;
                    $display("FAIL %s_latency: tri_valid=%b required 1", name, tri_valid);
                end
            end
        end
        drain();
        check_queues(name);
        do_end();
    endtask

    task automatic test_backpressure();
        logic [575:0] held;
        tri_ready = 1'b0;
        do_begin(0);
        for (int i = 0; i < 3; i++) drive_vert(rnd96(), rnd96());
        held = exp_q[0];
        vertex_in = rnd96(); color_in = rnd96(); vert_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (vert_ready !== 1'b0 || tri_valid !== 1'b1 ||
                {tri_v0, tri_v1, tri_v2, tri_c0, tri_c1, tri_c2} !== held) begin
                errors++;
                $display("FAIL stall_cycle%0d: vert_ready=%b tri_valid=%b required 0/1 stable",
                         i, vert_ready, tri_valid);
            end
        end
        @(posedge clk); #1;
        tri_ready = 1'b1;
        #1;
        checks++;
        if (vert_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_ready: got %b required 1", vert_ready);
        end
        @(posedge clk); #1;
        vert_valid = 1'b0;
        model_accept(vertex_in, color_in);
        drive_vert(rnd96(), rnd96());
        drive_vert(rnd96(), rnd96());
        drain();
        check_queues("backpressure");
        do_end();
    endtask

    task automatic test_end_discard();
        tri_ready = 1'b1;
        do_begin(0);
        drive_vert(rnd96(), rnd96());
        drive_vert(rnd96(), rnd96());
        do_end();
        checks++;
        if (active !== 1'b0) begin
            errors++;
            $display("FAIL end_active: got %b required 0", active);
        end
        do_begin(0);
        checks++;
        if (active !== 1'b1) begin
            errors++;
            $display("FAIL begin_active: got %b required 1", active);
        end
        for (int i = 0; i < 3; i++) drive_vert(rnd96(), rnd96());
        drain();
        check_queues("end_discard");
        do_end();
    endtask

    task automatic test_reset_mid();
        tri_ready = 1'b1;
        do_begin(1);
        for (int i = 0; i < 4; i++) drive_vert(rnd96(), rnd96());
        tri_ready = 1'b0;
        void'(exp_q.pop_back());  // second strip triangle is lost to reset
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (tri_valid !== 1'b0 || active !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: tri_valid=%b active=%b required 0/0", tri_valid, active);
        end
        reset = 1'b0;
        check_queues("reset_mid_pre");
        run_seq(1, 5, "strip_after_reset");
    endtask

    task automatic test_random();
        tri_ready = 1'b1;
        rnd_ready = 1;
        for (int r = 0; r < 6; r++) begin
            do_begin($urandom_range(0, 3));
            for (int i = 0; i < $urandom_range(3, 12); i++) drive_vert(rnd96(), rnd96());
            if ($urandom_range(0, 1) == 1) do_end();
        end
        rnd_ready = 0;
        @(posedge clk); #2;
        drain();
        check_queues("random");
        do_end();
    endtask

    initial begin
        test_reset();
        run_seq(0, 6, "list");
        run_seq(1, 5, "strip");
        run_seq(2, 5, "fan");
        test_backpressure();
        test_end_discard();
        test_reset_mid();
        run_seq(3, 6, "rsvd_mode");
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
